// File: rtl/axi_ic_pkg.sv
// Shared constants for the AXI interconnect read path: FSM encoding, response
// codes and the decoder's special select codes.
package axi_ic_pkg;

    localparam int ADDR_W = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FWD_AR = 3'd1;
    localparam logic [2:0] FWD_R  = 3'd2;
    localparam logic [2:0] ERR_AR = 3'd3;
    localparam logic [2:0] ERR_R  = 3'd4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] DEC_UNMAPPED = 3'b110;
    localparam logic [2:0] DEC_RST      = 3'b111;

    // A select is routable only when the decoder flags no error and the code
    // names a slave that actually exists in this configuration.
    function automatic logic dec_routable(input logic [2:0] code, input logic err, input int nslv);
        return !(err || code == DEC_UNMAPPED || code == DEC_RST || int'(code) >= nslv);
    endfunction

endpackage

// File: rtl/axi_read_router_if.sv
// Bus bundle between the upstream master/decoder, the router and its slaves.
// The router connects through the slave modport; the master modport is the mirror view.
interface axi_read_router_if #(
    parameter int NSLV = 6,
    parameter int DW   = 32
);
    logic [axi_ic_pkg::ADDR_W-1:0] ARADDR;
    logic [7:0]          ARLEN;
    logic                ARVALID;
    logic                ARREADY;
    logic [2:0]          dec_cntrl;
    logic                dec_error;
    logic [NSLV-1:0]     s_ARVALID;
    logic [NSLV-1:0]     s_ARREADY;
    logic [NSLV*DW-1:0]  s_RDATA;
    logic [NSLV*2-1:0]   s_RRESP;
    logic [NSLV-1:0]     s_RLAST;
    logic [NSLV-1:0]     s_RVALID;
    logic [NSLV-1:0]     s_RREADY;
    logic [DW-1:0]       RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;
    logic                to_flag;

    modport slave (
        input  ARADDR, ARLEN, ARVALID, dec_cntrl, dec_error,
        input  s_ARREADY, s_RDATA, s_RRESP, s_RLAST, s_RVALID, RREADY,
        output ARREADY, s_ARVALID, s_RREADY, RDATA, RRESP, RLAST, RVALID, to_flag
    );

    modport master (
        output ARADDR, ARLEN, ARVALID, dec_cntrl, dec_error,
        output s_ARREADY, s_RDATA, s_RRESP, s_RLAST, s_RVALID, RREADY,
        input  ARREADY, s_ARVALID, s_RREADY, RDATA, RRESP, RLAST, RVALID, to_flag
    );

endinterface

// File: rtl/axi_err_beat_gen.sv
// Locally generated error response burst: counts len+1 beats carrying a fixed
// response code with zero data, and reports when the final beat is accepted.
module axi_err_beat_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] len,
    input  logic [1:0] resp,
    input  logic       active,
    input  logic       rready,
    output logic       rvalid,
    output logic       rlast,
    output logic [1:0] rresp,
    output logic       done
);

    logic [7:0] cnt_reg;
    logic [1:0] resp_reg;

    // Counting down to zero means ARLEN=255 gives 256 beats without the counter wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            resp_reg <= 2'b00;
        end else if (load) begin
            cnt_reg  <= len;
            resp_reg <= resp;
        end else if (active && rready && cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign rvalid = active;
    assign rlast  = active && (cnt_reg == 8'd0);
    assign rresp  = active ? resp_reg : 2'b00;
    assign done   = active && rready && (cnt_reg == 8'd0);

endmodule

// File: rtl/axi_read_router.sv
// Read-channel router: forwards AR to the decoded slave and muxes its R channel
// back, or answers unmapped reads locally. Optional watchdog: ROUTER_TIMEOUT_EN.
module axi_read_router
    import axi_ic_pkg::*;
#(
    parameter int          NSLV   = 6,
    parameter int          DW     = 32,
    parameter int unsigned TO_CYC = 256
) (
    input logic            ACLK,
    input logic            ARESETN,
    axi_read_router_if.slave bus
);

    logic [2:0] state_reg, state_next;
    logic [2:0] sel_reg, sel_next;
    logic [7:0] len_reg, len_next;
    logic [1:0] err_resp_reg, err_resp_next;

    logic in_fwd_ar, in_fwd_r, in_err_ar, in_err_r;
    logic slv_arready, mux_rvalid, mux_rlast;
    logic [DW-1:0] mux_rdata;
    logic [1:0]    mux_rresp;
    logic [NSLV-1:0] sel_oh;
    logic [DW-1:0] rdata_term [NSLV];
    logic [1:0]    rresp_term [NSLV];
    logic err_rvalid, err_rlast, err_done;
    logic [1:0] err_rresp;
    logic wd_hit;

    assign in_fwd_ar = (state_reg == FWD_AR);
    assign in_fwd_r  = (state_reg == FWD_R);
    assign in_err_ar = (state_reg == ERR_AR);
    assign in_err_r  = (state_reg == ERR_R);

    // AND-OR mux keyed by a one-hot decode of the latched select.
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
        assign sel_oh[gi]     = (sel_reg == 3'(gi));
        assign rdata_term[gi] = bus.s_RDATA[gi*DW +: DW] & {DW{sel_oh[gi]}};
        assign rresp_term[gi] = bus.s_RRESP[gi*2 +: 2] & {2{sel_oh[gi]}};
    end

    always_comb begin
        mux_rdata = '0;
        mux_rresp = OKAY;
        for (int k = 0; k < NSLV; k++) begin
            mux_rdata = mux_rdata | rdata_term[k];
            mux_rresp = mux_rresp | rresp_term[k];
        end
    end

    assign mux_rvalid  = |(bus.s_RVALID & sel_oh);
    assign mux_rlast   = |(bus.s_RLAST & sel_oh);
    assign slv_arready = |(bus.s_ARREADY & sel_oh);

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        len_next      = len_reg;
        err_resp_next = err_resp_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ARVALID) begin
                    sel_next = bus.dec_cntrl;
                    len_next = bus.ARLEN;
                    if (dec_routable(bus.dec_cntrl, bus.dec_error, NSLV)) begin
                        state_next = FWD_AR;
                    end else begin
                        state_next    = ERR_AR;
                        err_resp_next = DECERR;
                    end
                end
            end
            FWD_AR: begin
                if (slv_arready) begin
                    state_next = FWD_R;
                end else if (wd_hit) begin
                    state_next    = ERR_AR;
                    err_resp_next = SLVERR;
                end
            end
            FWD_R: begin
                // The slave's RLAST ends the burst; beats are not counted here.
                if (mux_rvalid && bus.RREADY && mux_rlast) state_next = IDLE;
            end
            ERR_AR:  state_next = ERR_R;
            ERR_R: begin
                if (err_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg    <= IDLE;
            sel_reg      <= 3'd0;
            len_reg      <= 8'd0;
            err_resp_reg <= OKAY;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            len_reg      <= len_next;
            err_resp_reg <= err_resp_next;
        end
    end

`ifdef ROUTER_TIMEOUT_EN
    localparam int WD_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

    logic [WD_W-1:0] wd_reg;
    logic            to_flag_reg;

    // Fires on the TO_CYC-th consecutive FWD_AR cycle without slave acceptance.
    assign wd_hit = in_fwd_ar && !slv_arready && (wd_reg == WD_W'(TO_CYC - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_reg      <= '0;
            to_flag_reg <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                wd_reg <= '0;
            end else if (in_fwd_ar && !slv_arready) begin
                wd_reg <= wd_reg + 1'b1;
            end
            if (wd_hit) to_flag_reg <= 1'b1;
        end
    end

    assign bus.to_flag = to_flag_reg;
`else
    assign wd_hit      = 1'b0;
    assign bus.to_flag = 1'b0;
`endif

    axi_err_beat_gen u_err_beat_gen (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .load   (in_err_ar),
        .len    (len_reg),
        .resp   (err_resp_reg),
        .active (in_err_r),
        .rready (bus.RREADY),
        .rvalid (err_rvalid),
        .rlast  (err_rlast),
        .rresp  (err_rresp),
        .done   (err_done)
    );

    assign bus.s_ARVALID = in_fwd_ar ? sel_oh : '0;
    assign bus.ARREADY   = (in_fwd_ar && slv_arready) || in_err_ar;
    assign bus.s_RREADY  = (in_fwd_r && bus.RREADY) ? sel_oh : '0;
    assign bus.RVALID    = in_fwd_r ? mux_rvalid : err_rvalid;
    assign bus.RLAST     = in_fwd_r ? mux_rlast : err_rlast;
    assign bus.RRESP     = in_fwd_r ? mux_rresp : err_rresp;
    assign bus.RDATA     = in_fwd_r ? mux_rdata : '0;

    // ARADDR only feeds the external decoder; TO_CYC matters only with the watchdog.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ARADDR, TO_CYC[0]};

endmodule

// File: tb/tb_axi_read_router.sv
// Self-checking bench for axi_read_router: random slave/master behaviour checked
// against a transaction-level model of routing and local error responses.
module tb_axi_read_router;

    localparam int NSLV = 6;
    localparam int DW   = 32;
`ifdef ROUTER_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 256;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_to_flag = 1'b0;

    always #5 clk = ~clk;

    axi_read_router_if #(.NSLV(NSLV), .DW(DW)) bus ();

    axi_read_router #(.NSLV(NSLV), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    logic [2*NSLV+DW+5:0] all_outs;
    assign all_outs = {bus.ARREADY, bus.s_ARVALID, bus.s_RREADY, bus.RVALID,
                       bus.RLAST, bus.RRESP, bus.RDATA, bus.to_flag};

    task automatic drive_idle();
        bus.ARADDR    = '0;
        bus.ARLEN     = '0;
        bus.ARVALID   = 1'b0;
        bus.dec_cntrl = 3'b111;
        bus.dec_error = 1'b0;
        bus.s_ARREADY = '0;
        bus.s_RDATA   = '0;
        bus.s_RRESP   = '0;
        bus.s_RLAST   = '0;
        bus.s_RVALID  = '0;
        bus.RREADY    = 1'b0;
    endtask

    // Unselected slaves babble random traffic; none of it may reach the master.
    task automatic scramble_slaves(input int keep);
        for (int k = 0; k < NSLV; k++) begin
            if (k != keep) begin
                bus.s_ARREADY[k]          = 1'($urandom);
                bus.s_RVALID[k]           = 1'($urandom);
                bus.s_RLAST[k]            = 1'($urandom);
                bus.s_RDATA[k*DW +: DW]   = $urandom;
                bus.s_RRESP[k*2 +: 2]     = 2'($urandom);
            end
        end
    endtask

    // One read transaction. kind 0 = routed, 1 = decode error, 2 = watchdog expiry.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] dec,
                           input logic derr, input int rr_mode, input bit stuck,
                           input int abort_beat, input string tag);
        int kind, c, beats, ar_wait, nbeats, ar_cyc;
        bit ar_done, done, slave_valid, aborted;
        logic rr;
        logic [1:0] err_code;
        logic [NSLV-1:0] oh, exp_sarvalid, exp_srready;
        logic exp_arready, exp_rvalid, exp_rlast;
        logic [DW-1:0] exp_rdata;
        logic [1:0] exp_rresp;
        logic [DW-1:0] q_data[$];
        logic [1:0] q_resp[$];

        nbeats = int'(len) + 1;
        if (derr || int'(dec) >= NSLV) kind = 1;
        else if (stuck) kind = 2;
        else kind = 0;
        err_code = (kind == 2) ? 2'b10 : 2'b11;
        ar_cyc   = (kind == 2) ? TO_CYC + 1 : 1;
        oh = '0;
        if (kind != 1) oh[dec] = 1'b1;
        c = 0; beats = 0; ar_wait = 0;
        ar_done = 0; done = 0; slave_valid = 0; aborted = 0; rr = 1'b1;

        while (!done && c < 3000) begin
            @(negedge clk);
            if (abort_beat >= 0 && ar_done && beats == abort_beat) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if (all_outs !== '0) begin
                    n_fail++;
                    $display("FAIL %s async_reset: outputs %h, required all zero", tag, all_outs);
                end
                exp_to_flag = 1'b0;
                drive_idle();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    bus.RREADY   = 1'b1;
                    bus.s_RVALID = '1;
                    bus.s_RLAST  = '1;
                    #1;
                    n_checks++;
                    if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s post_reset_idle: RVALID=%b ARREADY=%b, required 0 0",
                                 tag, bus.RVALID, bus.ARREADY);
                    end
                end
                drive_idle();
                aborted = 1;
                done = 1;
            end else begin
                bus.ARVALID   = !ar_done;
                bus.ARADDR    = addr;
                bus.ARLEN     = ar_done ? 8'($urandom) : len;
                bus.dec_cntrl = ar_done ? 3'($urandom) : dec;
                bus.dec_error = ar_done ? 1'($urandom) : derr;
                scramble_slaves(kind == 1 ? -1 : int'(dec));
                if (kind != 1) begin
                    bus.s_ARREADY[dec] = stuck ? 1'b0 : ((ar_wait > 6) || ($urandom_range(0, 3) != 0));
                    bus.s_RVALID[dec]  = 1'b0;
                    if (kind == 0 && ar_done) begin
                        if (!slave_valid) slave_valid = (rr_mode == 1) || ($urandom_range(0, 2) != 0);
                        bus.s_RVALID[dec]        = slave_valid;
                        bus.s_RDATA[dec*DW +: DW] = q_data[beats];
                        bus.s_RRESP[dec*2 +: 2]   = q_resp[beats];
                        bus.s_RLAST[dec]         = (beats == nbeats - 1);
                    end
                end
                if (rr_mode == 0) rr = 1'b1;
                else if (rr_mode == 1) rr = (c % 2 == 0);
                else rr = 1'($urandom);
                bus.RREADY = rr;
                #1;

                if (kind == 2 && c == TO_CYC + 1) exp_to_flag = 1'b1;
                if (kind == 0) begin
                    exp_arready  = (c >= 1 && !ar_done) ? bus.s_ARREADY[dec] : 1'b0;
                    exp_sarvalid = (c >= 1 && !ar_done) ? oh : '0;
                    exp_srready  = (ar_done && rr) ? oh : '0;
                    exp_rvalid   = ar_done && slave_valid;
                    exp_rdata    = exp_rvalid ? q_data[beats] : '0;
                    exp_rresp    = exp_rvalid ? q_resp[beats] : 2'b00;
                end else begin
                    exp_arready  = (c == ar_cyc);
                    exp_sarvalid = (kind == 2 && c >= 1 && c <= TO_CYC) ? oh : '0;
                    exp_srready  = '0;
                    exp_rvalid   = ar_done;
                    exp_rdata    = '0;
                    exp_rresp    = err_code;
                end
                exp_rlast = (beats == nbeats - 1);

                n_checks++;
                if (bus.ARREADY !== exp_arready) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d ARREADY: got %b required %b", tag, c, bus.ARREADY, exp_arready);
                end
                n_checks++;
                if (bus.s_ARVALID !== exp_sarvalid) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d s_ARVALID: got %b required %b", tag, c, bus.s_ARVALID, exp_sarvalid);
                end
                n_checks++;
                if (bus.s_RREADY !== exp_srready) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d s_RREADY: got %b required %b", tag, c, bus.s_RREADY, exp_srready);
                end
                n_checks++;
                if (bus.RVALID !== exp_rvalid) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d RVALID: got %b required %b", tag, c, bus.RVALID, exp_rvalid);
                end
                n_checks++;
                if (bus.to_flag !== exp_to_flag) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d to_flag: got %b required %b", tag, c, bus.to_flag, exp_to_flag);
                end
                if (exp_rvalid) begin
                    n_checks++;
                    if ({bus.RDATA, bus.RRESP, bus.RLAST} !== {exp_rdata, exp_rresp, exp_rlast}) begin
                        n_fail++;
                        $display("FAIL %s beat%0d data/resp/last: got %h/%b/%b required %h/%b/%b",
                                 tag, beats, bus.RDATA, bus.RRESP, bus.RLAST, exp_rdata, exp_rresp, exp_rlast);
                    end
                end

                if (!ar_done && exp_arready) begin
                    ar_done = 1;
                    if (kind == 0) begin
                        for (int i = 0; i < nbeats; i++) begin
                            q_data.push_back($urandom);
                            q_resp.push_back(2'($urandom));
                        end
                    end
                end else if (!ar_done && c >= 1) begin
                    ar_wait++;
                end else if (exp_rvalid && rr) begin
                    beats++;
                    slave_valid = 0;
                    if (beats == nbeats) done = 1;
                end
                c++;
            end
        end

        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s completion: got %0d beats after %0d cycles, required %0d beats", tag, beats, c, nbeats);
        end
        $display("txn %s: kind=%0d len=%0d beats=%0d cycles=%0d aborted=%0d", tag, kind, len, beats, c, aborted);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ARVALID   = 1'b1;
            bus.dec_cntrl = 3'(i);
            bus.RREADY    = 1'b1;
            scramble_slaves(-1);
            #1;
            n_checks++;
            if (all_outs !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: outputs %h, required all zero", i, all_outs);
            end
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs %h, required all zero", all_outs);
        end
        $display("txn reset: done");
    endtask

    task automatic test_routed();
        do_read(32'h4011_0010, 8'd3, 3'd1, 1'b0, 2, 1'b0, -1, "routed_s1");
        for (int i = 0; i < 6; i++)
            do_read($urandom, 8'($urandom_range(0, 7)), 3'(i), 1'b0, 2, 1'b0, -1, "routed_rand");
    endtask

    task automatic test_decerr();
        do_read(32'h5000_0000, 8'd2, 3'd2, 1'b1, 0, 1'b0, -1, "decerr_flag");
        do_read($urandom, 8'($urandom_range(0, 5)), 3'b110, 1'b0, 2, 1'b0, -1, "decerr_code6");
        do_read($urandom, 8'($urandom_range(0, 5)), 3'b111, 1'b0, 2, 1'b0, -1, "decerr_code7");
    endtask

    task automatic test_stall();
        do_read(32'h7000_0040, 8'd3, 3'd3, 1'b0, 1, 1'b0, -1, "stall_s3");
    endtask

    task automatic test_reset_mid_burst();
        do_read(32'h6000_0000, 8'd7, 3'd4, 1'b0, 0, 1'b0, 2, "rst_mid");
        do_read(32'h6800_0000, 8'd0, 3'd5, 1'b0, 0, 1'b0, -1, "after_rst_s5");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            do_read($urandom, 8'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 4) == 0), 2, 1'b0, -1, "b2b");
    endtask

    task automatic test_long_decerr();
        do_read(32'hF000_0000, 8'd255, 3'b111, 1'b0, 2, 1'b0, -1, "decerr_256");
    endtask

`ifdef ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        do_read(32'h1000_0000, 8'd3, 3'd0, 1'b0, 2, 1'b1, -1, "timeout_s0");
        do_read(32'h1000_0100, 8'd1, 3'd2, 1'b0, 2, 1'b0, -1, "after_timeout");
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_routed();
        test_decerr();
        test_stall();
        test_reset_mid_burst();
        test_back_to_back();
        test_long_decerr();
`ifdef ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
